uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART link, sitting on the `rx` end of the UART interface. The transmitter drives the line; this block recovers frames from it.
- Samples the asynchronous line at 16x the baud rate, deframes start/data/parity/stop bits, and presents each byte on a valid/ready output with error flags.
- Feeds the receive side of the UART agent/DUT datapath.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..8), LSB first on the line
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)
DIV_WIDTH, 16, width of the baud divisor input

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
baud_div  input  DIV_WIDTH  clk cycles per oversample tick (16 ticks per bit); value 0 is treated as 1
rx_data  output  DATA_WIDTH  received data word
rx_valid  output  1  rx_data and flags hold a frame
rx_ready  input  1  consumer accepts the frame when rx_valid&&rx_ready
parity_err  output  1  parity mismatch for the presented frame
frame_err  output  1  a stop bit was sampled low for the presented frame
overrun_err  output  1  one-cycle pulse: a frame completed while rx_valid was still pending
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0, FSM=IDLE. Synchronizer flops reset to 1.
- Synchronizer: rx passes through 2 flops (rx_s) before any use.
- Tick generator: counter loads baud_div-1 and decrements each clk; tick=1 on the cycle it reaches 0, then it reloads.
  - The counter restarts on every IDLE->START transition, so sampling phase aligns to the start edge.
- Sample counter: 4 bits, increments per tick and wraps 15->0. Each bit period is 16 ticks.
  - Bit value is the majority of rx_s at ticks 7, 8 and 9 of that bit, registered at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on a falling edge of rx_s, go to START with the sample count cleared.
  - START: at tick 9, if the majority is 1 (false start), go to IDLE with no output. Otherwise, at tick 15, go to DATA with bit index 0.
  - DATA: shift the majority bit into the shift register at tick 9, LSB first. At tick 15, advance the bit index. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compute the expected parity over the data bits (even: XOR; odd: ~XOR). At tick 9, latch the mismatch. At tick 15, go to STOP.
  - STOP: at tick 9 of each stop bit, a 0 sets the frame-error latch.
    - At tick 9 of the final stop bit, the frame completes:
      - If rx_valid=0 or it is being accepted that cycle: load rx_data, parity_err, frame_err and set rx_valid on the next clk edge (latency: 1 clk after the final tick 9).
      - Otherwise, pulse overrun_err for 1 clk, drop the new frame, and leave the held frame unchanged.
    - Next state after completion: if the final stop sample is 0, go to WAIT_IDLE; else go to IDLE immediately (before tick 15, allowing back-to-back frames).
  - WAIT_IDLE: remain until rx_s=1 (break condition), then go to IDLE. No output is produced for a held-low line.
- Handshake:
  - rx_valid stays high, with rx_data and flags stable, until the cycle where rx_valid&&rx_ready. It clears on the next edge unless a new frame loads that same cycle; in that case rx_valid stays 1 with the new contents.
  - rx_ready is don't-care while rx_valid=0.
- baud_div changes take effect at the next counter reload. Changing it mid-frame is unsupported; the resulting frame content is undefined but the FSM must not lock up.
- Reset mid-frame: immediate return to the reset state. A partial frame is never presented.
- busy=1 in every state except IDLE.

Test Plan:
- Base frame:
  - Stimulus: baud_div=4 (64 clk/bit), DATA_WIDTH=8, no parity, 1 stop; drive 0xA5 (line 0,1,0,1,0,0,1,0,1,1).
  - Required: rx_data=0xA5, rx_valid=1 one clk after the stop mid-sample, all error flags 0. Hold rx_ready=0 for 100 clk and confirm rx_valid and data stay stable.
- Parity:
  - Stimulus: PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity 1, then 0x07 with parity 0.
  - Required: parity_err=0 on the first frame, parity_err=1 on the second; rx_data=0x07 both times.
- Framing and break:
  - Stimulus: send 0x3C with stop bit 0, then hold the line low for 3 bit times, then release high and send 0x81.
  - Required: 0x3C with frame_err=1, exactly one output during the low period, then 0x81 with frame_err=0.
- False start:
  - Stimulus: 0-pulse of 3 ticks (12 clk at baud_div=4) on an idle line.
  - Required: no rx_valid, FSM back to IDLE (busy=0) by tick 10.
- Overrun and back-to-back:
  - Stimulus: rx_ready=0; send 0x11 then 0x22 with no idle gap.
  - Required: 0x11 is held, overrun_err pulses 1 clk at the completion of 0x22; after rx_ready=1, rx_data=0x11 and then rx_valid=0.
  - Repeat with rx_ready=1: both 0x11 and 0x22 are delivered, no overrun_err.
- Async reset:
  - Stimulus: assert reset=0 during data bit 4 of 0xFF; release; send 0x5A.
  - Required: all outputs 0 immediately, no partial frame output, then 0x5A delivered with no error flags.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted deframer with valid/ready output
// and parity, framing and overrun error reporting.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned SMP_W  = 4;
    localparam logic        ODD    = (PARITY_ODD != 0);
    localparam logic        HAS_PAR = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_meta, rx_s, rx_s_d;
    logic [DIV_WIDTH-1:0]    div_cnt;
    logic [SMP_W-1:0]        smp_cnt;
    logic                    s7, s8;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [IDX_W-1:0]        bit_idx;
    logic                    stop_idx;
    logic                    par_err_q, fr_err_q;

    logic [DIV_WIDTH-1:0]    div_m1_c;
    logic [SMP_W-1:0]        smp_nxt_c;
    logic                    tick_c, at7_c, at8_c, at9_c, at15_c;
    logic                    maj_c, par_exp_c;
    logic                    start_c, shift_c, bit_inc_c, par_latch_c;
    logic                    stop_inc_c, fr_set_c, done_c, load_c;

    // Tick k of a bit is the tick that moves the sample count to k.
    assign div_m1_c  = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
    assign tick_c    = (div_cnt == '0);
    assign smp_nxt_c = smp_cnt + SMP_W'(1);
    assign at7_c     = tick_c && (smp_nxt_c == SMP_W'(7));
    assign at8_c     = tick_c && (smp_nxt_c == SMP_W'(8));
    assign at9_c     = tick_c && (smp_nxt_c == SMP_W'(9));
    assign at15_c    = tick_c && (smp_nxt_c == SMP_W'(15));
    assign maj_c     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign par_exp_c = (^shreg) ^ ODD;
    assign load_c    = done_c && (!rx_valid || rx_ready);

    // Two-flop synchronizer plus delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Oversample tick and sample counters, phase-aligned to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            div_cnt <= (start_c || tick_c) ? div_m1_c : div_cnt - DIV_WIDTH'(1);
            if (start_c)
                smp_cnt <= '0;
            else if (tick_c)
                smp_cnt <= smp_nxt_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        shift_c     = 1'b0;
        bit_inc_c   = 1'b0;
        par_latch_c = 1'b0;
        stop_inc_c  = 1'b0;
        fr_set_c    = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_s_d && !rx_s) begin
                    state_d = S_START;
                    start_c = 1'b1;
                end
            end
            S_START: begin
                if (at9_c && maj_c)
                    state_d = S_IDLE;
                else if (at15_c)
                    state_d = S_DATA;
            end
            S_DATA: begin
                shift_c = at9_c;
                if (at15_c) begin
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1))
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    else
                        bit_inc_c = 1'b1;
                end
            end
            S_PARITY: begin
                par_latch_c = at9_c;
                if (at15_c)
                    state_d = S_STOP;
            end
            S_STOP: begin
                fr_set_c = at9_c && !maj_c;
                if (at9_c && (stop_idx == 1'(STOP_BITS - 1))) begin
                    done_c  = 1'b1;
                    state_d = maj_c ? S_IDLE : S_WAIT_IDLE;
                end else if (at15_c) begin
                    stop_inc_c = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mid-bit samples, shift register and per-frame error latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s7        <= 1'b1;
            s8        <= 1'b1;
            shreg     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_err_q <= 1'b0;
            fr_err_q  <= 1'b0;
        end else begin
            if (at7_c)
                s7 <= rx_s;
            if (at8_c)
                s8 <= rx_s;
            if (shift_c)
                shreg <= {maj_c, shreg[DATA_WIDTH-1:1]};
            if (start_c) begin
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
                par_err_q <= 1'b0;
                fr_err_q  <= 1'b0;
            end else begin
                if (bit_inc_c)
                    bit_idx <= bit_idx + IDX_W'(1);
                if (stop_inc_c)
                    stop_idx <= 1'b1;
                if (par_latch_c)
                    par_err_q <= maj_c ^ par_exp_c;
                if (fr_set_c)
                    fr_err_q <= 1'b1;
            end
        end
    end

    // Output holding register; a completed frame is dropped if the previous one is still held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= done_c && !load_c;
            busy        <= (state_d != S_IDLE);
            if (load_c) begin
                rx_data    <= shreg;
                parity_err <= par_err_q;
                frame_err  <= fr_err_q | !maj_c;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: u0 is the 8N1 receiver, u1 the even-parity receiver.
module tb_uart_rx;

    localparam int unsigned BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic        rx_ready = 1'b0;
    logic        p_ready = 1'b0;
    logic [15:0] baud_div = 16'd4;

    logic [7:0]  rx_data, p_data;
    logic        rx_valid, parity_err, frame_err, overrun_err, busy;
    logic        p_valid, p_parity_err, p_frame_err, p_overrun_err, p_busy;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rises = 0;
    int          rise_cyc = 0;
    int          ovr_cycles = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  cap[$];

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .rx(rx0), .baud_div(baud_div),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .DIV_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .rx(rx1), .baud_div(baud_div),
        .rx_data(p_data), .rx_valid(p_valid), .rx_ready(p_ready),
        .parity_err(p_parity_err), .frame_err(p_frame_err), .overrun_err(p_overrun_err), .busy(p_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe u0 on the falling edge: valid rises, overrun pulse width, accepted words.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rises = rises + 1;
            rise_cyc = cyc;
        end
        if (overrun_err)
            ovr_cycles = ovr_cycles + 1;
        if (rx_valid && rx_ready)
            cap.push_back(rx_data);
        prev_valid = rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive_bit(input int sel, input logic v);
        if (sel == 0)
            rx0 = v;
        else
            rx1 = v;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_v);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(sel, d[i]);
        if (par_en)
            drive_bit(sel, par_bit);
        drive_bit(sel, stop_v);
    endtask

    task automatic accept0();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic accept1();
        p_ready = 1'b1;
        @(posedge clk);
        #1;
        p_ready = 1'b0;
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, r0, o0, n0, bad;

        // Reset state
        idle_clk(4);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        idle_clk(20);

        // Base frame 0xA5 and hold while not ready
        c0 = cyc;
        o0 = ovr_cycles;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check_eq("base_latency", 32'(rise_cyc - c0), 32'd615);
        check_eq("base_valid", 32'(rx_valid), 32'd1);
        check_eq("base_data", 32'(rx_data), 32'hA5);
        check_eq("base_flags", 32'({parity_err, frame_err}), 32'd0);
        check_eq("base_ovr", 32'(ovr_cycles - o0), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(rx_valid === 1'b1 && rx_data === 8'hA5 && frame_err === 1'b0))
                bad++;
        end
        check_eq("base_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        accept0();
        check_eq("base_cleared", 32'(rx_valid), 32'd0);
        idle_clk(20);

        // Parity on the even-parity instance
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        check_eq("par_ok_valid", 32'(p_valid), 32'd1);
        check_eq("par_ok_data", 32'(p_data), 32'h07);
        check_eq("par_ok_err", 32'({p_parity_err, p_frame_err}), 32'd0);
        accept1();
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        check_eq("par_bad_data", 32'(p_data), 32'h07);
        check_eq("par_bad_err", 32'({p_parity_err, p_frame_err}), 32'b10);
        accept1();
        idle_clk(20);

        // Framing error, then break held low, then a clean frame
        r0 = rises;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle_clk(3 * BIT_CLK);
        check_eq("brk_outputs", 32'(rises - r0), 32'd1);
        check_eq("brk_data", 32'(rx_data), 32'h3C);
        check_eq("brk_frame_err", 32'(frame_err), 32'd1);
        check_eq("brk_busy", 32'(busy), 32'd1);
        accept0();
        rx0 = 1'b1;
        idle_clk(BIT_CLK);
        check_eq("brk_released", 32'(busy), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        check_eq("brk_next_data", 32'(rx_data), 32'h81);
        check_eq("brk_next_ferr", 32'(frame_err), 32'd0);
        accept0();
        idle_clk(20);

        // False start: 12 clk low pulse
        r0 = rises;
        rx0 = 1'b0;
        idle_clk(12);
        rx0 = 1'b1;
        check_eq("fs_busy_on", 32'(busy), 32'd1);
        idle_clk(31);
        check_eq("fs_busy_off", 32'(busy), 32'd0);
        idle_clk(100);
        check_eq("fs_no_output", 32'(rises - r0), 32'd0);
        check_eq("fs_valid", 32'(rx_valid), 32'd0);

        // Overrun with back-to-back frames
        r0 = rises;
        o0 = ovr_cycles;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_pulse", 32'(ovr_cycles - o0), 32'd1);
        check_eq("ovr_rises", 32'(rises - r0), 32'd1);
        check_eq("ovr_held", 32'(rx_data), 32'h11);
        check_eq("ovr_valid", 32'(rx_valid), 32'd1);
        accept0();
        check_eq("ovr_cleared", 32'(rx_valid), 32'd0);
        idle_clk(20);

        // Back-to-back with the consumer always ready
        rx_ready = 1'b1;
        n0 = cap.size();
        o0 = ovr_cycles;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle_clk(4);
        rx_ready = 1'b0;
        check_eq("b2b_count", 32'(cap.size() - n0), 32'd2);
        if (cap.size() >= n0 + 2) begin
            check_eq("b2b_first", 32'(cap[n0]), 32'h11);
            check_eq("b2b_second", 32'(cap[n0+1]), 32'h22);
        end
        check_eq("b2b_no_ovr", 32'(ovr_cycles - o0), 32'd0);
        idle_clk(20);

        // Async reset during data bit 4 of 0xFF, with a held frame pending
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
        check_eq("ar_pending", 32'(rx_valid), 32'd1);
        rx0 = 1'b0;
        idle_clk(BIT_CLK);
        rx0 = 1'b1;
        idle_clk(4 * BIT_CLK + 32);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_valid", 32'(rx_valid), 32'd0);
        check_eq("ar_data", 32'(rx_data), 32'd0);
        check_eq("ar_flags", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        idle_clk(10);
        reset = 1'b1;
        r0 = rises;
        idle_clk(6 * BIT_CLK);
        check_eq("ar_no_partial", 32'(rises - r0), 32'd0);
        check_eq("ar_idle", 32'({rx_valid, busy}), 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check_eq("ar_next_valid", 32'(rx_valid), 32'd1);
        check_eq("ar_next_data", 32'(rx_data), 32'h5A);
        check_eq("ar_next_flags", 32'({parity_err, frame_err}), 32'd0);
        accept0();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
